// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add controller.
//   state_t       : FSM state encodings (IDLE=0, RUN=1, FIN=2)
//   DEFAULT_WIDTH : default operand/sum width in bits
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_1bit.sv
// Single full-adder cell, time-shared by serial_adder_ctrl.
// Ports:
//   A, B  in  : operand bits
//   Cin   in  : carry in
//   S     out : sum bit
//   Cout  out : carry out
module adder_1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one
// bit per clock, through a single adder_1bit cell. {Cout,S} = A + B + Cin.
// Ports:
//   CLK   in  : system clock, rising edge
//   RST   in  : synchronous active-high reset
//   START in  : request, sampled only in IDLE
//   A, B  in  : operands, captured on the accept edge
//   Cin   in  : initial carry, captured on the accept edge
//   BUSY  out : high from the accept edge until DONE clears
//   DONE  out : one-cycle pulse, S/Cout hold a new result
//   S     out : registered sum, changes only when a result completes or on reset
//   Cout  out : registered carry-out of the MSB
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only the upper WIDTH-1 result bits need storing: the final bit comes
  // straight from the cell on the last RUN edge.
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             cell_s;
  logic             cell_cout;
  logic [WIDTH-1:0] shifted;

  // Partial sum after this edge's bit enters at the MSB.
  assign shifted = {cell_s, sum_sh};

  adder_1bit u_cell (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .S    (cell_s),
    .Cout (cell_cout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      S      <= '0;
      Cout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= Cin;
            sum_sh <= '0;
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_sh <= shifted[WIDTH-1:1];
          carry  <= cell_cout;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          if (cnt == LAST) begin
            // Last bit: publish the whole result at once so S/Cout never
            // show a partial sum.
            S     <= shifted;
            Cout  <= cell_cout;
            DONE  <= 1'b1;
            state <= ST_FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
